// File: rtl/icache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : icache_assoc
// Brief    : Set-associative instruction cache, AXI4 burst refill,
//            uncached bypass window and fence_i whole-cache flush.
// Revision : 1.0
// ============================================================================
module icache_assoc #(
    parameter int          WAYS        = 2,
    parameter int          SETS        = 16,
    parameter int          BLOCK_WORDS = 4,
    parameter logic [31:0] BYPASS_BASE = 32'h0f00_0000,
    parameter logic [31:0] BYPASS_SIZE = 32'h00ff_ffff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fence_i,
    output logic        flush_done,
    input  logic        cpu_arvalid,
    output logic        cpu_arready,
    input  logic [31:0] cpu_araddr,
    output logic        cpu_rvalid,
    input  logic        cpu_rready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rerr,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    output logic [31:0] axi_araddr,
    output logic [7:0]  axi_arlen,
    output logic [2:0]  axi_arsize,
    output logic [1:0]  axi_arburst,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rlast,
    output logic        hit,
    output logic        miss
);

    localparam int c_OFF_W = $clog2(BLOCK_WORDS);
    localparam int c_IDX_W = $clog2(SETS);
    localparam int c_TAG_W = 32 - c_IDX_W - c_OFF_W - 2;
    localparam int c_WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [3:0] c_S_IDLE        = 4'd0;
    localparam logic [3:0] c_S_LOOKUP      = 4'd1;
    localparam logic [3:0] c_S_REFILL_ADDR = 4'd2;
    localparam logic [3:0] c_S_REFILL_DATA = 4'd3;
    localparam logic [3:0] c_S_BYPASS_ADDR = 4'd4;
    localparam logic [3:0] c_S_BYPASS_DATA = 4'd5;
    localparam logic [3:0] c_S_RESP        = 4'd6;
    localparam logic [3:0] c_S_FLUSH       = 4'd7;

    logic [3:0]          r_state;
    logic [3:0]          w_state_nxt;
    logic [31:2]         r_addr;
    logic                r_flush_pend;
    logic [c_IDX_W-1:0]  r_flush_idx;
    logic [c_WAY_W-1:0]  r_victim;
    logic [c_OFF_W-1:0]  r_beat;
    logic                r_refill_err;
    logic [31:0]         r_rdata;
    logic                r_rerr;
    logic [31:0]         r_axi_araddr;
    logic [7:0]          r_axi_arlen;

    logic [WAYS-1:0]     r_valid [SETS];
    logic [c_WAY_W-1:0]  r_rr    [SETS];
    logic [c_TAG_W-1:0]  r_tag   [WAYS][SETS];
    logic [31:0]         r_data  [WAYS][SETS][BLOCK_WORDS];

    logic [c_TAG_W-1:0]  w_tag;
    logic [c_IDX_W-1:0]  w_idx;
    logic [c_OFF_W-1:0]  w_off;
    logic [WAYS-1:0]     w_match;
    logic [31:0]         w_hit_word;
    logic                w_hit;
    logic                w_has_inv;
    logic [c_WAY_W-1:0]  w_victim;
    logic [c_WAY_W-1:0]  w_rr_next;
    logic [32:0]         w_byp_end;
    logic                w_bypass;
    logic                w_beat_err;

    assign w_tag = r_addr[31 -: c_TAG_W];
    assign w_idx = r_addr[c_OFF_W+2 +: c_IDX_W];
    assign w_off = r_addr[2 +: c_OFF_W];

    // 33-bit end so a window touching the top of the address space cannot wrap
    assign w_byp_end  = {1'b0, BYPASS_BASE} + {1'b0, BYPASS_SIZE};
    assign w_bypass   = (cpu_araddr >= BYPASS_BASE) && ({1'b0, cpu_araddr} < w_byp_end);
    assign w_beat_err = (axi_rresp != 2'b00);

    always_comb begin
        w_match    = '0;
        w_hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
                w_match[w] = 1'b1;
                w_hit_word = w_hit_word | r_data[w][w_idx][w_off];
            end
        end
    end
    assign w_hit = |w_match;

    always_comb begin
        w_has_inv = 1'b0;
        w_victim  = r_rr[w_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_has_inv = 1'b1;
                w_victim  = c_WAY_W'(w);
            end
        end
    end
    assign w_rr_next = (WAYS == 1) ? '0 : r_rr[w_idx] + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (r_flush_pend)     w_state_nxt = c_S_FLUSH;
                else if (cpu_arvalid) w_state_nxt = w_bypass ? c_S_BYPASS_ADDR : c_S_LOOKUP;
            end
            c_S_LOOKUP:      w_state_nxt = w_hit ? c_S_RESP : c_S_REFILL_ADDR;
            c_S_REFILL_ADDR: if (axi_arready) w_state_nxt = c_S_REFILL_DATA;
            c_S_REFILL_DATA: if (axi_rvalid && axi_rlast) w_state_nxt = c_S_RESP;
            c_S_BYPASS_ADDR: if (axi_arready) w_state_nxt = c_S_BYPASS_DATA;
            c_S_BYPASS_DATA: if (axi_rvalid) w_state_nxt = c_S_RESP;
            c_S_RESP:        if (cpu_rready) w_state_nxt = c_S_IDLE;
            c_S_FLUSH:       if (r_flush_idx == c_IDX_W'(SETS - 1)) w_state_nxt = c_S_IDLE;
            default:         w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_flush_pend <= 1'b0;
            r_flush_idx  <= '0;
            r_victim     <= '0;
            r_beat       <= '0;
            r_refill_err <= 1'b0;
            r_rdata      <= '0;
            r_rerr       <= 1'b0;
            r_axi_araddr <= '0;
            r_axi_arlen  <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            if (fence_i && (r_state != c_S_FLUSH)) r_flush_pend <= 1'b1;
            case (r_state)
                c_S_IDLE: begin
                    if (r_flush_pend) begin
                        r_flush_pend <= 1'b0;
                        r_flush_idx  <= '0;
                    end else if (cpu_arvalid) begin
                        r_addr <= cpu_araddr[31:2];
                        r_rerr <= 1'b0;
                        if (w_bypass) begin
                            r_axi_araddr <= cpu_araddr;
                            r_axi_arlen  <= 8'd0;
                        end
                    end
                end
                c_S_LOOKUP: begin
                    if (w_hit) begin
                        // Round-robin replacement carries no per-hit state
                        r_rdata <= w_hit_word;
                    end else begin
                        r_victim                 <= w_victim;
                        r_valid[w_idx][w_victim] <= 1'b0;
                        if (!w_has_inv) r_rr[w_idx] <= w_rr_next;
                        r_beat       <= '0;
                        r_refill_err <= 1'b0;
                        r_axi_araddr <= {r_addr[31:c_OFF_W+2], {(c_OFF_W+2){1'b0}}};
                        r_axi_arlen  <= 8'(BLOCK_WORDS - 1);
                    end
                end
                c_S_REFILL_DATA: begin
                    if (axi_rvalid) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == w_off) r_rdata <= axi_rdata;
                        if (w_beat_err) r_refill_err <= 1'b1;
                        if (axi_rlast) begin
                            r_rerr <= r_refill_err | w_beat_err;
                            if (!r_refill_err && !w_beat_err) r_valid[w_idx][r_victim] <= 1'b1;
                        end
                    end
                end
                c_S_BYPASS_DATA: begin
                    if (axi_rvalid) begin
                        r_rdata <= axi_rdata;
                        r_rerr  <= w_beat_err;
                    end
                end
                c_S_FLUSH: begin
                    r_valid[r_flush_idx] <= '0;
                    r_rr[r_flush_idx]    <= '0;
                    r_flush_idx          <= r_flush_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays need no reset: valid bits gate every use
    always_ff @(posedge clk) begin
        if ((r_state == c_S_LOOKUP) && !w_hit) r_tag[w_victim][w_idx] <= w_tag;
        if ((r_state == c_S_REFILL_DATA) && axi_rvalid) r_data[r_victim][w_idx][r_beat] <= axi_rdata;
    end

    assign cpu_arready = !rst && (r_state == c_S_IDLE) && !r_flush_pend;
    assign cpu_rvalid  = (r_state == c_S_RESP);
    assign cpu_rdata   = r_rdata;
    assign cpu_rerr    = r_rerr;
    assign axi_arvalid = (r_state == c_S_REFILL_ADDR) || (r_state == c_S_BYPASS_ADDR);
    assign axi_araddr  = r_axi_araddr;
    assign axi_arlen   = r_axi_arlen;
    assign axi_arsize  = 3'b010;
    assign axi_arburst = 2'b01;
    assign axi_rready  = (r_state == c_S_REFILL_DATA) || (r_state == c_S_BYPASS_DATA);
    assign hit         = (r_state == c_S_LOOKUP) && w_hit;
    assign miss        = (r_state == c_S_LOOKUP) && !w_hit;
    assign flush_done  = (r_state == c_S_FLUSH) && (r_flush_idx == c_IDX_W'(SETS - 1));

endmodule
`default_nettype wire
